// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// An 8-entry (2^DEPTH_LOG2) byte FIFO feeds an 8N1 serializer. The line idles high.
// Bursts of pushes queue up while the frame in flight finishes.
// Optional feature macro: UART_TX_FIFO_PARITY_EN.
//   When defined, an even-parity bit follows the data bits (8E1 framing, 11 bits).
//   When undefined, no parity logic is built (8N1 framing, 10 bits).
// Every output comes straight from a flop.
// Serial/active/done are computed from the next state, so they line up with the state register.

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_TX_DV,
    input  logic [7:0]            i_TX_Byte,
    output logic                  o_FIFO_Full,
    output logic [DEPTH_LOG2:0]   o_FIFO_Count,
    output logic                  o_Overflow,
    output logic                  o_TX_Active,
    output logic                  o_TX_Serial,
    output logic                  o_TX_Done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]         C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   C_DEPTH     = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_FIFO_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } t_state;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]            r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_count_next;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    t_state                r_state;
    t_state                w_state_next;
    logic [CW-1:0]         r_baud;
    logic [CW-1:0]         w_baud_next;
    logic [2:0]            r_bit;
    logic [2:0]            w_bit_next;
    logic [7:0]            r_tx_data;
    logic                  r_serial;
    logic                  r_active;
    logic                  r_done;
    logic                  w_serial_next;
    logic                  w_active_next;
    logic                  w_done_next;

    // A push is judged against the registered count only.
    // A pop in the same cycle does not make room for it.
    assign w_push = i_TX_DV && (r_count < C_DEPTH);

    // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + (DEPTH_LOG2 + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - (DEPTH_LOG2 + 1)'(1);
        end
    end

    // Storage array plus head read into the frame register.
    // Neither is reset, so the array infers as RAM.
    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_TX_Byte;
        end
        if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    // Pointers, count, full flag and the drop pulse.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == C_DEPTH);
            r_overflow <= i_TX_DV && (r_count == C_DEPTH);
        end
    end

    // Next-state logic.
    // Line/active/done are derived from the state being entered, so they register together with it.
    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud;
        w_bit_next    = r_bit;
        w_pop         = 1'b0;
        w_done_next   = 1'b0;
        w_serial_next = 1'b1;
        w_active_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The Done cycle is also IDLE.
                // A queued byte launches here, leaving a single idle-high clock between frames.
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_baud_next  = '0;
                end
            end
            S_START: begin
                if (r_baud == C_BAUD_LAST) begin
                    w_state_next = S_DATA;
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                end else begin
                    w_baud_next = r_baud + CW'(1);
                end
            end
            S_DATA: begin
                if (r_baud == C_BAUD_LAST) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_FIFO_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + CW'(1);
                end
            end
`ifdef UART_TX_FIFO_PARITY_EN
            S_PARITY: begin
                if (r_baud == C_BAUD_LAST) begin
                    w_state_next = S_STOP;
                    w_baud_next  = '0;
                end else begin
                    w_baud_next = r_baud + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (r_baud == C_BAUD_LAST) begin
                    w_state_next = S_IDLE;
                    w_baud_next  = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_baud_next = r_baud + CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
                w_bit_next   = 3'd0;
            end
        endcase

        // Line level for the state being entered.
        // DATA is only reached after a pop, so r_tx_data is valid there.
        case (w_state_next)
            S_START:  w_serial_next = 1'b0;
            S_DATA:   w_serial_next = r_tx_data[w_bit_next];
`ifdef UART_TX_FIFO_PARITY_EN
            S_PARITY: w_serial_next = ^r_tx_data;
`endif
            default:  w_serial_next = 1'b1;
        endcase
        w_active_next = (w_state_next != S_IDLE);
    end

    // State register and registered line outputs.
    // Reset forces the line high immediately and aborts any frame.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= 3'd0;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_serial <= w_serial_next;
            r_active <= w_active_next;
            r_done   <= w_done_next;
        end
    end

    assign o_FIFO_Full  = r_full;
    assign o_FIFO_Count = r_count;
    assign o_Overflow   = r_overflow;
    assign o_TX_Active  = r_active;
    assign o_TX_Serial  = r_serial;
    assign o_TX_Done    = r_done;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: an 8-entry byte FIFO feeding an 8N1 serializer, with the line held high when idle.
- Sits on the TX side of UART loopback and console designs. Producers such as UART RX, command parsers or hex formatters can push bytes in bursts without waiting for the frame in flight to finish.
- Replaces the direct-drive pattern "active ? serial : 1" in top levels. The line is always valid out of this block.

Parameters:
- CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200). Minimum 2.
- DEPTH_LOG2, 3, log2 of FIFO depth (default depth 8).

Ports:
- i_Clk  in  1  system clock; all logic on its rising edge
- i_Rst_L  in  1  synchronous reset, active low
- i_TX_DV  in  1  one-cycle push strobe for i_TX_Byte
- i_TX_Byte  in  8  byte to enqueue; sampled when i_TX_DV=1
- o_FIFO_Full  out  1  FIFO holds 2^DEPTH_LOG2 bytes; further pushes are dropped
- o_FIFO_Count  out  DEPTH_LOG2+1  bytes currently queued, excluding the byte being serialized
- o_Overflow  out  1  one-cycle pulse when a push is dropped
- o_TX_Active  out  1  high from the first start-bit cycle through the last stop-bit cycle
- o_TX_Serial  out  1  UART line; 1 when idle
- o_TX_Done  out  1  one-cycle pulse on the cycle after a stop bit completes

Behaviour:
- Reset (i_Rst_L=0 at an edge):
  - FIFO flushed; o_FIFO_Count=0, o_FIFO_Full=0, o_Overflow=0.
  - FSM=IDLE; o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0.
  - Reset mid-frame aborts the frame. The line is high from the next edge and no Done pulse is issued.
- FIFO:
  - Circular buffer with read and write pointers of DEPTH_LOG2 bits, wrapping modulo depth. Count is one bit wider.
  - Push accepted iff i_TX_DV=1 and the registered count < depth.
  - A push while full is dropped and o_Overflow=1 on the next cycle. FIFO contents and pointers are unchanged.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - No bypass: a byte pushed into an empty FIFO is visible to the FSM one cycle later.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: line=1, Active=0. If count>0: pop the head into an 8-bit shift register, then go to START.
  - START: line=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: LSB first, 8 bits of CLKS_PER_BIT cycles each. A 3-bit index counts 0..7; after bit 7, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles, then IDLE with o_TX_Done=1 for that first IDLE cycle.
  - The baud counter runs 0..CLKS_PER_BIT-1 and clears on every state change. Its width is clog2(CLKS_PER_BIT).
- Latency:
  - Push at cycle N into an empty FIFO with the FSM in IDLE: pop at N+1, start bit on the line from N+2.
  - Back-to-back frames: the Done/IDLE cycle also pops the next byte, so there is exactly 1 idle-high clock between frames.
- All outputs are registered. o_TX_Serial must be glitch-free and never X after reset.

Optional Feature:
- Macro: UART_TX_FIFO_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits (8E1). o_TX_Active covers the parity bit.
- Undefined:
  - No PARITY state and no parity logic. Frame is 10 bits (8N1).

Test Plan:
- Reset, then push 0x55 once (CLKS_PER_BIT=4):
  - Start bit at push+2.
  - Line sequence: 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - o_TX_Active high for 40 cycles, then o_TX_Done pulse.
  - o_FIFO_Count 1 for one cycle, then 0.
- Push 0xA3 then 0x0F on consecutive cycles:
  - Two frames with data bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
  - Exactly 1 high idle cycle between the frames; two Done pulses.
- Push 10 bytes 0x00..0x09 on consecutive cycles (depth 8):
  - 0x00 popped immediately; count reaches 8; o_FIFO_Full=1.
  - 0x09 dropped with one o_Overflow pulse.
  - Line carries 0x00..0x08 in order.
- Assert reset at bit 3 of a 0xFF frame with 3 bytes queued:
  - Line high next cycle; count=0; Active=0; no Done pulse.
  - No further frames after release.
- Push while the FSM pops in the same cycle with count=8:
  - Push rejected (registered full).
  - Count goes to 7; overflow pulse.
- With UART_TX_FIFO_PARITY_EN defined, push 0x07:
  - Parity bit=1; frame 11 bits (44 cycles at CLKS_PER_BIT=4).
  - Undefined: 40 cycles and no parity bit.
